// File: rtl/affine_seq.sv
// Affine pixel transform sequencer: drives an external combinational ALU one op per
// clock to compute x' = a11*x + a12*y + b1 and y' = a21*x + a22*y + b2.
module affine_seq #(
  parameter int         n         = 8,
  parameter logic [2:0] FUNC_RA   = 3'd0,
  parameter logic [2:0] FUNC_RADD = 3'd1,
  parameter logic [2:0] FUNC_RMUL = 3'd2
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] x_in,
  input  logic [n-1:0] y_in,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [n-1:0] cfg_data,
  output logic         cfg_err,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [2:0]   alu_func,
  input  logic [n-1:0] alu_result,
  input  logic         alu_flag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic         x_zero,
  output logic         y_zero,
  output logic         busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_M1, S_M2, S_A1, S_B1, S_M3, S_M4, S_A2, S_B2, S_DONE
  } state_t;

  localparam int NCOEF = 6;
  localparam int C_A11 = 0;
  localparam int C_A12 = 1;
  localparam int C_A21 = 2;
  localparam int C_A22 = 3;
  localparam int C_B1  = 4;
  localparam int C_B2  = 5;

  state_t       state_q, state_d;
  logic [n-1:0] coef_q [NCOEF];
  logic [n-1:0] coef_d [NCOEF];
  // Snapshot of the coefficients taken when a pair is accepted, so a write landing
  // on the same edge only affects the following pair.
  logic [n-1:0] act_q  [NCOEF];
  logic [n-1:0] act_d  [NCOEF];
  logic [n-1:0] x_q, x_d, y_q, y_d;
  logic [n-1:0] t0_q, t0_d, t1_q, t1_d;
  logic [n-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic         x_zero_q, x_zero_d, y_zero_q, y_zero_d;
  logic         cfg_err_q, cfg_err_d;
  logic         cfg_open;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= '0;
        act_q[i]  <= '0;
      end
      x_q       <= '0;
      y_q       <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      x_zero_q  <= 1'b0;
      y_zero_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= coef_d[i];
        act_q[i]  <= act_d[i];
      end
      x_q       <= x_d;
      y_q       <= y_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      x_zero_q  <= x_zero_d;
      y_zero_q  <= y_zero_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    coef_d    = coef_q;
    act_d     = act_q;
    x_d       = x_q;
    y_d       = y_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    x_zero_d  = x_zero_q;
    y_zero_d  = y_zero_q;
    cfg_err_d = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_func  = FUNC_RA;

    if (cfg_we) begin
      if (cfg_open && (cfg_addr < 3'd6)) begin
        for (int i = 0; i < NCOEF; i++) begin
          if (cfg_addr == i[2:0]) coef_d[i] = cfg_data;
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          act_d   = coef_q;
          state_d = S_M1;
        end
      end
      S_M1: begin
        alu_a = x_q; alu_b = act_q[C_A11]; alu_func = FUNC_RMUL;
        t0_d = alu_result; state_d = S_M2;
      end
      S_M2: begin
        alu_a = y_q; alu_b = act_q[C_A12]; alu_func = FUNC_RMUL;
        t1_d = alu_result; state_d = S_A1;
      end
      S_A1: begin
        alu_a = t0_q; alu_b = t1_q; alu_func = FUNC_RADD;
        t0_d = alu_result; state_d = S_B1;
      end
      S_B1: begin
        alu_a = t0_q; alu_b = act_q[C_B1]; alu_func = FUNC_RADD;
        x_out_d = alu_result; x_zero_d = alu_flag; state_d = S_M3;
      end
      S_M3: begin
        alu_a = x_q; alu_b = act_q[C_A21]; alu_func = FUNC_RMUL;
        t0_d = alu_result; state_d = S_M4;
      end
      S_M4: begin
        alu_a = y_q; alu_b = act_q[C_A22]; alu_func = FUNC_RMUL;
        t1_d = alu_result; state_d = S_A2;
      end
      S_A2: begin
        alu_a = t0_q; alu_b = t1_q; alu_func = FUNC_RADD;
        t0_d = alu_result; state_d = S_B2;
      end
      S_B2: begin
        alu_a = t0_q; alu_b = act_q[C_B2]; alu_func = FUNC_RADD;
        y_out_d = alu_result; y_zero_d = alu_flag; state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign x_zero    = x_zero_q;
  assign y_zero    = y_zero_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_affine_seq.sv
// Bench for affine_seq: models the ALU, keeps a transaction-level reference of the
// transform, and checks the DUT every cycle plus hand-computed directed results.
module tb_affine_seq;
  localparam logic [2:0] RA = 3'd0, RADD = 3'd1, RMUL = 3'd2;

  logic       clk = 1'b0, nReset = 1'b0;
  logic       in_valid = 1'b0, cfg_we = 1'b0, out_ready = 1'b0;
  logic [7:0] x_in = '0, y_in = '0, cfg_data = '0;
  logic [2:0] cfg_addr = '0;
  logic       in_ready, cfg_err, alu_flag, out_valid, x_zero, y_zero, busy;
  logic [7:0] alu_a, alu_b, alu_result, x_out, y_out;
  logic [2:0] alu_func;

  int errs = 0, checks = 0, cyc = 0, acc_cyc = 0;

  affine_seq #(.n(8), .FUNC_RA(RA), .FUNC_RADD(RADD), .FUNC_RMUL(RMUL)) dut (
    .clk(clk), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .alu_a(alu_a), .alu_b(alu_b),
    .alu_func(alu_func), .alu_result(alu_result), .alu_flag(alu_flag),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out),
    .x_zero(x_zero), .y_zero(y_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0]         bs;
    logic signed [15:0] p;
    bs = {b[6:0], 1'b0};
    p  = $signed(a) * $signed(bs);
    return p[14:7];
  endfunction

  // External combinational ALU
  always_comb begin
    case (alu_func)
      RMUL:    alu_result = rmul(alu_a, alu_b);
      RADD:    alu_result = alu_a + alu_b;
      default: alu_result = alu_a;
    endcase
    alu_flag = (alu_result == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = waiting, 1..8 = compute cycles, 9 = result held
  int         m_phase = 0, m_prev = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_coef [6] = '{default: 8'h00};
  logic [7:0] snap   [6];
  logic [7:0] e_a [1:8], e_b [1:8];
  logic [2:0] e_f [1:8];
  logic [7:0] e_x = '0, e_y = '0, p0, p1, p2, p3, sx, sy;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_phase = 0;
      m_err   = 1'b0;
      for (int i = 0; i < 6; i++) m_coef[i] = 8'h00;
    end else begin
      m_prev = m_phase;
      if (m_prev == 0 && in_valid) begin
        snap = m_coef;
        p0 = rmul(x_in, snap[0]); p1 = rmul(y_in, snap[1]);
        sx = p0 + p1;             e_x = sx + snap[4];
        p2 = rmul(x_in, snap[2]); p3 = rmul(y_in, snap[3]);
        sy = p2 + p3;             e_y = sy + snap[5];
        e_a = '{x_in, y_in, p0, sx, x_in, y_in, p2, sy};
        e_b = '{snap[0], snap[1], p1, snap[4], snap[2], snap[3], p3, snap[5]};
        e_f = '{RMUL, RMUL, RADD, RADD, RMUL, RMUL, RADD, RADD};
      end
      m_err = cfg_we && !((m_prev == 0 || m_prev == 9) && cfg_addr < 3'd6);
      if (cfg_we && !m_err) m_coef[cfg_addr] = cfg_data;
      if (m_prev == 0) begin
        if (in_valid) m_phase = 1;
      end else if (m_prev < 9) begin
        m_phase = m_prev + 1;
      end else if (out_ready) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (nReset) begin
      check("in_ready", in_ready, m_phase == 0);
      check("busy", busy, m_phase != 0);
      check("out_valid", out_valid, m_phase == 9);
      check("cfg_err", cfg_err, m_err);
      if (m_phase == 0) begin
        check("idle_func", alu_func, RA);
        check("idle_a", alu_a, 8'h00);
        check("idle_b", alu_b, 8'h00);
      end else if (m_phase <= 8) begin
        check($sformatf("alu_func@%0d", m_phase), alu_func, e_f[m_phase]);
        check($sformatf("alu_a@%0d", m_phase), alu_a, e_a[m_phase]);
        check($sformatf("alu_b@%0d", m_phase), alu_b, e_b[m_phase]);
      end else begin
        check("x_out", x_out, e_x);
        check("y_out", y_out, e_y);
        check("x_zero", x_zero, e_x == 8'h00);
        check("y_zero", y_zero, e_y == 8'h00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d, input logic exp_err);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    check($sformatf("cfg_err_addr%0d", a), cfg_err, exp_err);
    $display("cfg write addr=%0d data=0x%02h err=%0b", a, d, cfg_err);
  endtask

  task automatic start_pair(input logic [7:0] x, input logic [7:0] y);
    check("accept_ready", in_ready, 1'b1);
    x_in = x; y_in = y; in_valid = 1'b1;
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    while (!out_valid && (cyc - acc_cyc) < 20) tick();
    check("latency", cyc - acc_cyc, 9);
    $display("pair x=0x%02h y=0x%02h -> x_out=0x%02h y_out=0x%02h xz=%0b yz=%0b",
             x_in, y_in, x_out, y_out, x_zero, y_zero);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [7:0] t6a [8] = '{8'h10, 8'h20, 8'h08, 8'h18, 8'h10, 8'h20, 8'h00, 8'h00};
  logic [7:0] t6b [8] = '{8'h20, 8'h20, 8'h10, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [2:0] t6f [8] = '{RMUL, RMUL, RADD, RADD, RMUL, RMUL, RADD, RADD};

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_x_out", x_out, 8'h00);
    check("rst_y_out", y_out, 8'h00);
    check("rst_zero", {x_zero, y_zero}, 2'b00);
    check("rst_func", alu_func, RA);
    @(posedge clk);
    #3 nReset = 1'b1;
    tick();

    // Basic transform with a per-state ALU table
    cfg_write(3'd0, 8'h20, 1'b0);
    cfg_write(3'd1, 8'h20, 1'b0);
    cfg_write(3'd4, 8'h05, 1'b0);
    cfg_write(3'd2, 8'h00, 1'b0);
    cfg_write(3'd3, 8'h00, 1'b0);
    cfg_write(3'd5, 8'h00, 1'b0);
    start_pair(8'h10, 8'h20);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t6_func%0d", i), alu_func, t6f[i]);
      check($sformatf("t6_a%0d", i), alu_a, t6a[i]);
      check($sformatf("t6_b%0d", i), alu_b, t6b[i]);
      tick();
    end
    wait_done();
    check("t2_x_out", x_out, 8'h1D);
    check("t2_y_out", y_out, 8'h00);
    check("t2_zero", {x_zero, y_zero}, 2'b01);
    release_out();

    // Wrapping add; out_ready held high during compute is ignored
    cfg_write(3'd4, 8'h7F, 1'b0);
    out_ready = 1'b1;
    start_pair(8'h10, 8'h10);
    wait_done();
    check("t3_x_out", x_out, 8'h8F);
    tick();
    out_ready = 1'b0;
    check("t3_back_idle", in_ready, 1'b1);

    // Rejected write mid-compute, then a stalled result
    start_pair(8'h10, 8'h10);
    tick();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h40;
    tick();
    cfg_we = 1'b0;
    check("t4_busy_err", cfg_err, 1'b1);
    tick();
    check("t4_err_pulse", cfg_err, 1'b0);
    wait_done();
    check("t4_a11_kept", x_out, 8'h8F);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_x", x_out, 8'h8F);
      check("t5_hold_valid", out_valid, 1'b1);
      check("t5_hold_ready", in_ready, 1'b0);
    end
    release_out();
    check("t5_idle", {in_ready, out_valid}, 2'b10);

    // Back-to-back pair with a simultaneous coefficient write
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'h10;
    start_pair(8'h10, 8'h00);
    cfg_we = 1'b0;
    wait_done();
    check("t7_old_coef", x_out, 8'h87);
    check("t7_y_zero", y_zero, 1'b1);
    release_out();
    start_pair(8'h10, 8'h00);
    wait_done();
    check("t7_new_coef", x_out, 8'h83);
    release_out();
    cfg_write(3'd7, 8'h11, 1'b1);
    cfg_write(3'd6, 8'h22, 1'b1);

    // Asynchronous reset in M3
    start_pair(8'h10, 8'h20);
    repeat (4) tick();
    #2 nReset = 1'b0;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_out_valid", out_valid, 1'b0);
    check("t1_in_ready", in_ready, 1'b1);
    tick();
    #2 nReset = 1'b1;
    tick();
    start_pair(8'h10, 8'h20);
    wait_done();
    check("t1_coef_x", x_out, 8'h00);
    check("t1_coef_y", y_out, 8'h00);
    check("t1_zero", {x_zero, y_zero}, 2'b11);
    release_out();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
